downcount_timer: RTL

//   Loadable down-counting timer, the consuming counterpart of upcount.

---
 rtl/downcount_timer_pkg.sv | 14 +
 rtl/downcount_timer_if.sv | 25 ++
 rtl/downcount_timer_irq_latch.sv | 21 ++
 rtl/downcount_timer.sv | 73 +++++++
 4 files changed

// File: rtl/downcount_timer_pkg.sv
// downcount_timer_pkg: shared state encoding and default width for the down-counting timer
package downcount_timer_pkg;

    localparam int WIDTH_DEF = 4;

    // 2'd3 is unreachable in normal operation and recovers to IDLE
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        DONE    = 2'd2,
        ILLEGAL = 2'd3
    } state_e;

endpackage

// File: rtl/downcount_timer_if.sv
// downcount_timer_if: control inputs and status outputs of the down-counting timer
interface downcount_timer_if #(parameter int WIDTH = downcount_timer_pkg::WIDTH_DEF);

    logic             e_i;
    logic             load_i;
    logic [WIDTH-1:0] d_i;
    logic             auto_reload_i;
    logic             ack_i;
    logic [WIDTH-1:0] q_o;
    logic             zero_o;
    logic             tc_o;
    logic             irq_o;
    logic             busy_o;

    modport master (
        output e_i, load_i, d_i, auto_reload_i, ack_i,
        input  q_o, zero_o, tc_o, irq_o, busy_o
    );

    modport slave (
        input  e_i, load_i, d_i, auto_reload_i, ack_i,
        output q_o, zero_o, tc_o, irq_o, busy_o
    );

endinterface

// File: rtl/downcount_timer_irq_latch.sv
// irq_latch: sticky flag, set wins over clear, asynchronous reset
module irq_latch (
    input  logic clk,
    input  logic rst,
    input  logic set_i,
    input  logic clr_i,
    output logic flag_o
);

    logic flag_q;

    // set has priority so an event coinciding with an acknowledge is never lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        flag_q <= 1'b0;
        else if (set_i) flag_q <= 1'b1;
        else if (clr_i) flag_q <= 1'b0;
    end

    assign flag_o = flag_q;

endmodule

// File: rtl/downcount_timer.sv
// downcount_timer: loadable down-counter with terminal-count pulse, sticky IRQ and optional auto-reload
module downcount_timer
    import downcount_timer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    downcount_timer_if.slave bus
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] rl_q, rl_d;
    logic             tc_q;
    logic             term;

    // next state: load beats the terminal step, which beats a plain decrement
    always_comb begin
        state_d = state_q;
        q_d     = q_q;
        rl_d    = rl_q;
        term    = 1'b0;
        if (bus.load_i) begin
            q_d     = bus.d_i;
            rl_d    = bus.d_i;
            state_d = (bus.d_i != '0) ? RUN : IDLE;
        end else if (state_q == RUN && bus.e_i && q_q == ONE) begin
            term    = 1'b1;
            q_d     = bus.auto_reload_i ? rl_q : '0;
            state_d = bus.auto_reload_i ? RUN : DONE;
        end else if (state_q == RUN && bus.e_i && q_q != '0) begin
            q_d     = q_q - ONE;
        end else if (state_q == ILLEGAL) begin
            state_d = IDLE;
        end
    end

    // state, count and reload value update together
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            q_q     <= '0;
            rl_q    <= '0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            rl_q    <= rl_d;
        end
    end

    // terminal-count pulse lasts exactly the cycle after the terminal step
    always_ff @(posedge clk or posedge rst) begin
        if (rst) tc_q <= 1'b0;
        else     tc_q <= term;
    end

    irq_latch u_irq (
        .clk    (clk),
        .rst    (rst),
        .set_i  (term),
        .clr_i  (bus.ack_i),
        .flag_o (bus.irq_o)
    );

    assign bus.q_o    = q_q;
    assign bus.zero_o = (q_q == '0);
    assign bus.tc_o   = tc_q;
    assign bus.busy_o = (state_q == RUN);

endmodule
